// File: rtl/data_send_pkg.sv
// Shared constants and helpers for the com-RAM packet path (packet builder and data_send).
package data_send_pkg;

  localparam logic [3:0]  BAG_STAT                 = 4'h1;
  localparam logic [3:0]  BAG_DATA                 = 4'h5;
  localparam logic [15:0] COM_RAM_ADDR_IDLE        = 16'hF000;
  localparam logic [15:0] COM_RAM_ADDR_STAT        = 16'h2300;
  localparam logic [15:0] COM_RAM_ADDR_DATA_STRIDE = 16'h2400;
  localparam logic [3:0]  DATA_SLOT_MAX            = 4'd5;
  localparam int unsigned DATA_HDR_LEN             = 4;
  localparam int unsigned DLEN                     = 512;

  typedef logic [12:0] len_t;

  localparam len_t STAT_LEN = 13'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_READ,
    ST_DRAIN,
    ST_CSUM,
    ST_DONE
  } state_t;

  function automatic logic [15:0] data_base(input logic [3:0] idx);
    return 16'(idx * COM_RAM_ADDR_DATA_STRIDE);
  endfunction

  function automatic len_t data_len(input logic [7:0] dev_stat, input int unsigned dlen);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (dev_stat[i]) n++;
    end
    return len_t'(DATA_HDR_LEN + dlen * n);
  endfunction

endpackage

// File: rtl/data_send_if.sv
// Byte stream toward the USB FIFO: valid/ready handshake with a last-byte flag.
interface data_send_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/data_send_skid_fifo.sv
// First-word-fall-through skid FIFO absorbing RAM read latency under output backpressure.
module skid_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_send.sv
// Reads a finished STAT/DATA packet back from com RAM and streams it out with a trailing XOR checksum.
module data_send #(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned SKID_DEPTH  = 4,
  parameter int unsigned DLEN        = data_send_pkg::DLEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [3:0]  btype,
  input  logic [3:0]  data_idx,
  input  logic [7:0]  dev_stat,
  output logic [15:0] ram_rxa,
  input  logic [7:0]  ram_rxd,
  data_send_if.master tx
);
  import data_send_pkg::*;

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SUM_W = $clog2(SKID_DEPTH + RAM_LATENCY + 1);

  state_t state, state_nx;

  logic [3:0]             req_type;
  logic [3:0]             req_idx;
  logic [7:0]             req_stat;
  logic [15:0]            base;
  len_t                   len;
  len_t                   rd_cnt;
  logic [7:0]             csum;
  logic [RAM_LATENCY-1:0] vpipe;

  logic [SUM_W-1:0] inflight;
  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ram_rxd),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Credit counts reads still in the RAM pipe, so a full pipe can always land in the FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
      inflight = inflight + SUM_W'(vpipe[i]);
    end
  end

  assign credit_ok = ~fifo_full && ((SUM_W'(fifo_count) + inflight) < SUM_W'(SKID_DEPTH));
  assign issue     = (state == ST_READ) && (rd_cnt != len) && credit_ok;
  assign push      = vpipe[RAM_LATENCY-1];
  assign pop       = ~fifo_empty & tx.tx_ready;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = ST_WAIT;
      ST_WAIT:  if (fs && (btype == BAG_STAT || btype == BAG_DATA)) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = (req_type == BAG_DATA && req_idx > DATA_SLOT_MAX) ? ST_CSUM : ST_READ;
      ST_READ:  if (rd_cnt == len) state_nx = ST_DRAIN;
      ST_DRAIN: if (vpipe == '0 && (fifo_empty || (fifo_count == CNT_W'(1) && pop)))
                  state_nx = ST_CSUM;
      ST_CSUM:  if (tx.tx_ready) state_nx = ST_DONE;
      ST_DONE:  if (!fs) state_nx = ST_WAIT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The checksum byte is only presented once the FIFO has fully drained.
  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    tx.tx_last  = 1'b0;
    fd          = (state == ST_DONE);
    if (!fifo_empty) begin
      tx.tx_valid = 1'b1;
      tx.tx_data  = fifo_dout;
    end else if (state == ST_CSUM) begin
      tx.tx_valid = 1'b1;
      tx.tx_data  = csum;
      tx.tx_last  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      req_type <= '0;
      req_idx  <= '0;
      req_stat <= '0;
      base     <= '0;
      len      <= '0;
      rd_cnt   <= '0;
      csum     <= '0;
      vpipe    <= '0;
      ram_rxa  <= COM_RAM_ADDR_IDLE;
    end else begin
      state <= state_nx;
      vpipe <= {vpipe[RAM_LATENCY-2:0], issue};

      if (state == ST_WAIT && state_nx == ST_LOAD) begin
        req_type <= btype;
        req_idx  <= data_idx;
        req_stat <= dev_stat;
      end

      if (state == ST_LOAD) begin
        rd_cnt <= '0;
        csum   <= '0;
        if (req_type == BAG_STAT) begin
          base <= COM_RAM_ADDR_STAT;
          len  <= STAT_LEN;
        end else begin
          base <= data_base(req_idx);
          len  <= (req_idx > DATA_SLOT_MAX) ? '0 : data_len(req_stat, DLEN);
        end
      end else begin
        if (pop) csum <= csum ^ fifo_dout;
        if (issue) begin
          ram_rxa <= base + {3'b000, rd_cnt};
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule
